pipe_hazard_ctrl: RTL

//  Central stall/flush generator for the 5-stage pipeline. Drives the stall/flush inputs of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and the PC enable. Covers load-use hazards,

---
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: load-use, taken-branch squash, data-memory waits.
// Optional stall-cycle counter port enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int PERF_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              ex_memread_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              if_id_flush_o,
    output logic              id_ex_stall_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_stall_o,
    output logic              mem_wb_flush_o,
    output logic              busy_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic              err_o,
    output logic [PERF_W-1:0] perf_stall_cnt_o
`else
    output logic              err_o
`endif
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             err_reg, err_next;
    logic             mw, lu, mem_stall;

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        err_next       = err_reg;
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;

        mw = mem_req_i & ~mem_ack_i;
        lu = ex_memread_i && (ex_rd_i != 5'd0) &&
             ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
        mem_stall = ((state_reg == ST_RUN) && mw) || ((state_reg == ST_WAIT) && !mem_ack_i);

        // Gating with rst_i keeps every output low for the whole reset window.
        if (rst_i) begin
            if (mem_stall) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
                mem_wb_flush_o = 1'b1;
                if (state_reg == ST_RUN) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end else if (wait_cnt_reg != TIMEOUT_VAL) begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
                if (wait_cnt_next == TIMEOUT_VAL) begin
                    err_next = 1'b1;
                end
            end else begin
                if (state_reg == ST_WAIT) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end
                if (ex_branch_taken_i) begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end else if (lu) begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
        end
    end

    assign busy_o = (state_reg == ST_WAIT);
    assign err_o  = err_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_cnt_reg <= '0;
        end else if (pc_stall_o) begin
            perf_cnt_reg <= perf_cnt_reg + PERF_W'(1);
        end
    end

    assign perf_stall_cnt_o = perf_cnt_reg;
`endif

endmodule
